aq_djpeg_dequant: RTL and testbench
===================================

AQ_DJPEG_DEQUANT -- requirements
Module: aq_djpeg_dequant

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- DataInit  input  1  per-image pipeline/state clear, one-cycle pulse
- QtableWrite  input  1  quant-table entry write strobe
- QtableSel  input  1  table select: 0 = luma, 1 = chroma
- QtableAddress  input  6  zigzag index of the entry
- QtableData  input  8  unsigned quantiser value
- DataInEnable  input  1  coefficient valid from the Huffman decoder
- DataInAddress  input  6  zigzag index, 0-63
- DataInColor  input  3  component code: 0-3 = Y, 4 = Cb, 5 = Cr
- DataIn  input  16  signed coefficient
- HuffmanEndIn  input  1  end-of-block pulse
- DataInIdle  output  1  ready for a new block
- DataOutEnable  output  1  dequantised coefficient valid
- DataOutAddress  output  6  zigzag index, delayed
- DataOutColor  output  3  component, delayed
- DataOut  output  16  signed dequantised coefficient
- HuffmanEndEnable  output  1  delayed end-of-block pulse
- DataOutIdle  input  1  downstream zigzag buffer can accept a block

Function
REQ-003 Storage SHALL be two 64x8 table RAMs, addressed by {QtableSel, QtableAddress}; a write occurs when QtableWrite=1.
REQ-004 Table select for a coefficient SHALL be 0 when DataInColor<4 and 1 otherwise; codes 6-7 SHALL use table 1.
REQ-005 Pipeline latency SHALL be exactly 2 cycles: stage 1 registers the coefficient, address, color and table value; stage 2 registers the product.
REQ-006 DataOut SHALL equal DataIn (signed) x table value (unsigned) as a 24-bit signed product, saturated to [-32768, 32767].
REQ-007 DataOutAddress, DataOutColor and DataOutEnable SHALL be the stage-2 copies of their inputs.
REQ-008 HuffmanEndEnable SHALL be HuffmanEndIn delayed 2 cycles, so it never precedes the last coefficient of its block.
REQ-009 If a table write and a coefficient read hit the same entry in the same cycle, the read SHALL return the old value.
REQ-010 The control FSM SHALL have four states:
- S_IDLE: on DataInEnable -> S_ACTIVE.
- S_ACTIVE: on HuffmanEndIn -> S_DRAIN, and a 2-bit drain counter is loaded with 2.
- S_DRAIN: the counter decrements; at 0 -> S_IDLE.
- S_INIT: entered from any state on DataInit; returns to S_IDLE on the next cycle.
REQ-011 DataInIdle SHALL equal DataOutIdle AND (state==S_IDLE OR state==S_ACTIVE).
REQ-012 HuffmanEndIn with DataInEnable in the same cycle SHALL be legal; that coefficient is the block's last.
REQ-013 DataInEnable while in S_DRAIN SHALL be accepted into the pipeline (back-to-back blocks).
REQ-014 In S_DRAIN the FSM SHALL return to S_ACTIVE instead of S_IDLE when that happens.
REQ-015 DataInit SHALL clear both pipeline stages' valid and end flags.
REQ-016 DataInit SHALL NOT alter the table contents.

Reset
REQ-017 On rst=1 at a clock edge, the FSM SHALL go to S_IDLE and the drain counter to 0.
REQ-018 On rst=1, DataOutEnable and HuffmanEndEnable SHALL be 0.
REQ-019 On rst=1, DataOut, DataOutAddress and DataOutColor SHALL be 0.
REQ-020 Table RAMs SHALL NOT be reset; their contents are undefined until written.
REQ-021 Reset asserted mid-block SHALL drop all in-flight coefficients, with no output pulse afterwards.

Verification
REQ-022 Load luma entry 0 = 16; feed DataIn=5 (color 0, address 0) -> 2 cycles later DataOut=80, DataOutAddress=0, DataOutColor=0.
REQ-023 Load chroma entry 63 = 255; feed DataIn=1000 (color 5, address 63) -> DataOut=32767 (saturated).
REQ-024 Same table as REQ-023; feed DataIn=-1000 -> DataOut=-32768.
REQ-025 Feed a 64-coefficient block with HuffmanEndIn on the last beat -> HuffmanEndEnable is asserted in the same cycle as the last DataOutEnable.
REQ-026 With DataOutIdle=0 -> DataInIdle=0.
REQ-027 Write luma entry 3 = 2 and read entry 3 (previously 9) in the same cycle with DataIn=1 -> DataOut=9.
REQ-028 The following read of entry 3 -> DataOut=2.
REQ-029 Pulse DataInit or rst mid-block -> no DataOutEnable in the next 2 cycles, and DataInIdle=1 once the FSM returns to S_IDLE (given DataOutIdle=1).

Source files
------------

// File: rtl/aq_djpeg_dequant.sv
// ---------------------------------------------------------------------------
// aq_djpeg_dequant
//   JPEG decoder dequantiser. Each coefficient coming out of the Huffman
//   decoder is multiplied by the quantiser value for its zigzag index. The
//   quantiser value comes from the luma table for components 0-3 and from
//   the chroma table for all other codes. The product is saturated to
//   16 bits signed. The pipeline has two register stages:
//     stage 1: coefficient, address, color, table value, valid, end flag
//     stage 2: saturated product, address, color, valid, end flag
//
// Handshake (valid/ready): a coefficient is transferred on every clock edge
//   where DataInEnable=1. No back-pressure is applied per beat. DataInIdle
//   tells the Huffman decoder whether a new block may be started: this is
//   DataOutIdle (the downstream buffer can take a block) gated by the FSM
//   being in S_IDLE or S_ACTIVE. The upstream side is expected to honour it.
//   HuffmanEndIn marks the last beat of a block. It may arrive together with
//   that block's last coefficient.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   DataInit          per-image clear of pipeline flags and FSM (one pulse)
//   Qtable*           quant-table write port {QtableSel, QtableAddress}
//   DataIn*           coefficient input from the Huffman decoder
//   HuffmanEndIn      end-of-block pulse
//   DataInIdle        ready for a new block
//   DataOut*          dequantised coefficient, 2 cycles after input
//   HuffmanEndEnable  end-of-block pulse, aligned with the last output
//   DataOutIdle       downstream ready for a block
// ---------------------------------------------------------------------------
module aq_djpeg_dequant (
  input  logic        clk,
  input  logic        rst,
  input  logic        DataInit,
  input  logic        QtableWrite,
  input  logic        QtableSel,
  input  logic [5:0]  QtableAddress,
  input  logic [7:0]  QtableData,
  input  logic        DataInEnable,
  input  logic [5:0]  DataInAddress,
  input  logic [2:0]  DataInColor,
  input  logic [15:0] DataIn,
  input  logic        HuffmanEndIn,
  output logic        DataInIdle,
  output logic        DataOutEnable,
  output logic [5:0]  DataOutAddress,
  output logic [2:0]  DataOutColor,
  output logic [15:0] DataOut,
  output logic        HuffmanEndEnable,
  input  logic        DataOutIdle
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_INIT   = 2'd3
  } state_t;

  localparam logic signed [24:0] MaxValue = 25'sd32767;
  localparam logic signed [24:0] MinValue = -25'sd32768;

  // Quantiser tables; intentionally not reset.
  logic [7:0] lumaTable   [64];
  logic [7:0] chromaTable [64];

  state_t     state, nextState;
  logic [1:0] drainCount, nextCount;

  logic        valid1, end1;
  logic [5:0]  address1;
  logic [2:0]  color1;
  logic [15:0] data1;
  logic [7:0]  qValue1;

  logic              tableSel;
  logic signed [24:0] product;
  logic [15:0]       saturated;

  // Components 0-3 are luma; 4, 5 and the unused codes 6, 7 use chroma.
  assign tableSel = DataInColor[2];

  always_ff @(posedge clk) begin
    if (QtableWrite) begin
      if (QtableSel) chromaTable[QtableAddress] <= QtableData;
      else           lumaTable[QtableAddress]   <= QtableData;
    end
  end

  // Stage 1. The table read is non-blocking against the write above, so a
  // same-cycle write to the same entry leaves the old value in qValue1.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1   <= 1'b0;
      end1     <= 1'b0;
      address1 <= '0;
      color1   <= '0;
      data1    <= '0;
      qValue1  <= '0;
    end else begin
      valid1   <= DataInEnable & ~DataInit;
      end1     <= HuffmanEndIn & ~DataInit;
      address1 <= DataInAddress;
      color1   <= DataInColor;
      data1    <= DataIn;
      qValue1  <= tableSel ? chromaTable[DataInAddress] : lumaTable[DataInAddress];
    end
  end

  // Signed coefficient times unsigned quantiser (zero-extended to signed).
  assign product = $signed(data1) * $signed({1'b0, qValue1});

  always_comb begin
    saturated = product[15:0];
    if (product > MaxValue)      saturated = 16'h7fff;
    else if (product < MinValue) saturated = 16'h8000;
  end

  // Stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      DataOutEnable    <= 1'b0;
      HuffmanEndEnable <= 1'b0;
      DataOutAddress   <= '0;
      DataOutColor     <= '0;
      DataOut          <= '0;
    end else begin
      DataOutEnable    <= valid1 & ~DataInit;
      HuffmanEndEnable <= end1 & ~DataInit;
      DataOutAddress   <= address1;
      DataOutColor     <= color1;
      DataOut          <= saturated;
    end
  end

  // Control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      drainCount <= 2'd0;
    end else begin
      state      <= nextState;
      drainCount <= nextCount;
    end
  end

  always_comb begin
    nextState = state;
    nextCount = drainCount;
    if (DataInit) begin
      nextState = S_INIT;
      nextCount = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // A one-beat block (enable and end together) goes straight to drain.
          if (DataInEnable) begin
            if (HuffmanEndIn) begin
              nextState = S_DRAIN;
              nextCount = 2'd2;
            end else begin
              nextState = S_ACTIVE;
            end
          end
        end
        S_ACTIVE: begin
          if (HuffmanEndIn) begin
            nextState = S_DRAIN;
            nextCount = 2'd2;
          end
        end
        S_DRAIN: begin
          // A new block arriving during drain is accepted back-to-back.
          if (DataInEnable) begin
            if (HuffmanEndIn) begin
              nextCount = 2'd2;
            end else begin
              nextState = S_ACTIVE;
              nextCount = 2'd0;
            end
          end else if (drainCount == 2'd0) begin
            nextState = S_IDLE;
          end else begin
            nextCount = drainCount - 2'd1;
          end
        end
        S_INIT: begin
          nextState = S_IDLE;
        end
      endcase
    end
  end

  assign DataInIdle = DataOutIdle & ((state == S_IDLE) | (state == S_ACTIVE));

endmodule

// File: tb/tb_aq_djpeg_dequant.sv
module tb_aq_djpeg_dequant;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dataInit;
  logic        qtableWrite;
  logic        qtableSel;
  logic [5:0]  qtableAddress;
  logic [7:0]  qtableData;
  logic        dataInEnable;
  logic [5:0]  dataInAddress;
  logic [2:0]  dataInColor;
  logic [15:0] dataIn;
  logic        huffmanEndIn;
  logic        dataInIdle;
  logic        dataOutEnable;
  logic [5:0]  dataOutAddress;
  logic [2:0]  dataOutColor;
  logic [15:0] dataOut;
  logic        huffmanEndEnable;
  logic        dataOutIdle;

  aq_djpeg_dequant dut (
    .clk              (clk),
    .rst              (rst),
    .DataInit         (dataInit),
    .QtableWrite      (qtableWrite),
    .QtableSel        (qtableSel),
    .QtableAddress    (qtableAddress),
    .QtableData       (qtableData),
    .DataInEnable     (dataInEnable),
    .DataInAddress    (dataInAddress),
    .DataInColor      (dataInColor),
    .DataIn           (dataIn),
    .HuffmanEndIn     (huffmanEndIn),
    .DataInIdle       (dataInIdle),
    .DataOutEnable    (dataOutEnable),
    .DataOutAddress   (dataOutAddress),
    .DataOutColor     (dataOutColor),
    .DataOut          (dataOut),
    .HuffmanEndEnable (huffmanEndEnable),
    .DataOutIdle      (dataOutIdle)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic       en;
    logic       endf;
    logic [15:0] data;
    logic [5:0] addr;
    logic [2:0] color;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] lumaRef   [64];
  logic [7:0] chromaRef [64];
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: the model consumes the inputs currently driven, then the
  // outputs are compared 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    int   q;
    int   p;
    if (rst || dataInit) begin
      exp_q.delete();
    end else if (dataInEnable || huffmanEndIn) begin
      q = (dataInColor < 3'd4) ? int'(lumaRef[dataInAddress]) : int'(chromaRef[dataInAddress]);
      p = int'($signed(dataIn)) * q;
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
      e.due   = cyc + 2;
      e.en    = dataInEnable;
      e.endf  = huffmanEndIn;
      e.data  = p[15:0];
      e.addr  = dataInAddress;
      e.color = dataInColor;
      exp_q.push_back(e);
    end
    if (qtableWrite) begin
      if (qtableSel) chromaRef[qtableAddress] = qtableData;
      else           lumaRef[qtableAddress]   = qtableData;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("out_en", 32'(dataOutEnable), 32'(e.en));
      chk("out_end", 32'(huffmanEndEnable), 32'(e.endf));
      if (e.en) begin
        chk("out_data", 32'(dataOut), 32'(e.data));
        chk("out_addr", 32'(dataOutAddress), 32'(e.addr));
        chk("out_color", 32'(dataOutColor), 32'(e.color));
      end
    end else begin
      chk("out_en_idle", 32'(dataOutEnable), 32'd0);
      chk("out_end_idle", 32'(huffmanEndEnable), 32'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic setIn(input logic en, input logic [5:0] addr, input logic [2:0] color,
                       input logic [15:0] data, input logic endf);
    dataInEnable  = en;
    dataInAddress = addr;
    dataInColor   = color;
    dataIn        = data;
    huffmanEndIn  = endf;
  endtask

  task automatic clearIn();
    setIn(1'b0, 6'd0, 3'd0, 16'd0, 1'b0);
  endtask

  task automatic writeTable(input logic sel, input logic [5:0] addr, input logic [7:0] data);
    qtableWrite   = 1'b1;
    qtableSel     = sel;
    qtableAddress = addr;
    qtableData    = data;
    tick();
    qtableWrite   = 1'b0;
  endtask

  task automatic feedBlock(input int len);
    for (int i = 0; i < len; i++) begin
      setIn(1'b1, 6'(i), 3'($urandom_range(0, 5)), 16'($urandom), (i == len - 1) ? 1'b1 : 1'b0);
      tick();
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; dataInit = 1'b0; qtableWrite = 1'b0; qtableSel = 1'b0;
    qtableAddress = 6'd0; qtableData = 8'd0; dataOutIdle = 1'b1;
    clearIn();
    tick();
    tick();
    chk("rst_data", 32'(dataOut), 32'd0);
    chk("rst_addr", 32'(dataOutAddress), 32'd0);
    chk("rst_color", 32'(dataOutColor), 32'd0);
    chk("rst_idle", 32'(dataInIdle), 32'd1);
    rst = 1'b0;
    tick();

    // Fill both tables so every read has a defined value.
    for (int i = 0; i < 128; i++) begin
      writeTable((i >= 64) ? 1'b1 : 1'b0, 6'(i % 64), 8'($urandom_range(0, 255)));
    end
    writeTable(1'b0, 6'd0, 8'd16);
    writeTable(1'b1, 6'd63, 8'd255);
    writeTable(1'b0, 6'd3, 8'd9);

    // Luma 16 x 5.
    setIn(1'b1, 6'd0, 3'd0, 16'd5, 1'b0);
    tick();
    clearIn();
    tick();
    chk("luma_80", 32'(dataOut), 32'd80);
    chk("luma_80_en", 32'(dataOutEnable), 32'd1);

    // Chroma 255 saturation both ways.
    setIn(1'b1, 6'd63, 3'd5, 16'd1000, 1'b0);
    tick();
    setIn(1'b1, 6'd63, 3'd5, -16'sd1000, 1'b0);
    tick();
    chk("sat_pos", 32'(dataOut), 32'h7fff);
    clearIn();
    tick();
    chk("sat_neg", 32'(dataOut), 32'h8000);

    // Same-cycle write and read of luma entry 3.
    qtableWrite = 1'b1; qtableSel = 1'b0; qtableAddress = 6'd3; qtableData = 8'd2;
    setIn(1'b1, 6'd3, 3'd0, 16'd1, 1'b0);
    tick();
    qtableWrite = 1'b0;
    tick();
    chk("wr_rd_old", 32'(dataOut), 32'd9);
    clearIn();
    tick();
    chk("wr_rd_new", 32'(dataOut), 32'd2);

    // Full 64-coefficient block.
    feedBlock(64);
    clearIn();
    chk("drain_idle0", 32'(dataInIdle), 32'd0);
    tick();
    chk("last_en", 32'(dataOutEnable), 32'd1);
    chk("last_end", 32'(huffmanEndEnable), 32'd1);
    tick();
    chk("drain_idle1", 32'(dataInIdle), 32'd0);
    tick();
    chk("back_idle", 32'(dataInIdle), 32'd1);

    // Back-to-back blocks, the second starting during drain.
    feedBlock(8);
    feedBlock(8);
    feedBlock(1);
    clearIn();
    for (int i = 0; i < 5; i++) tick();
    chk("b2b_idle", 32'(dataInIdle), 32'd1);

    // Downstream not ready.
    dataOutIdle = 1'b0;
    tick();
    chk("down_busy", 32'(dataInIdle), 32'd0);
    dataOutIdle = 1'b1;

    // DataInit mid-block.
    feedBlock(0);
    for (int i = 0; i < 3; i++) begin
      setIn(1'b1, 6'(i), 3'd1, 16'($urandom), 1'b0);
      tick();
    end
    clearIn();
    dataInit = 1'b1;
    tick();
    dataInit = 1'b0;
    chk("init_state", 32'(dataInIdle), 32'd0);
    tick();
    chk("init_en", 32'(dataOutEnable), 32'd0);
    chk("init_idle", 32'(dataInIdle), 32'd1);
    // Tables survive DataInit.
    setIn(1'b1, 6'd0, 3'd2, 16'd5, 1'b0);
    tick();
    clearIn();
    tick();
    chk("init_table", 32'(dataOut), 32'd80);

    // Reset mid-block.
    for (int i = 0; i < 3; i++) begin
      setIn(1'b1, 6'(i), 3'd4, 16'($urandom), 1'b0);
      tick();
    end
    clearIn();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_en", 32'(dataOutEnable), 32'd0);
    tick();
    chk("rst_mid_idle", 32'(dataInIdle), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      setIn(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 6'($urandom_range(0, 63)),
            3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
      qtableWrite   = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      qtableSel     = 1'($urandom_range(0, 1));
      qtableAddress = 6'($urandom_range(0, 63));
      qtableData    = 8'($urandom_range(0, 255));
      dataInit      = ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0;
      dataOutIdle   = 1'($urandom_range(0, 1));
      tick();
    end
    clearIn();
    qtableWrite = 1'b0;
    dataInit    = 1'b0;
    dataOutIdle = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("final_idle", 32'(dataInIdle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
